// File: rtl/cache_l1_pkg.sv
// cache_l1_pkg: bus bundles, access-size codes and CACHE op encodings
// shared by the L1 data cache and its byte-lane extractor.
package cache_l1_pkg;

    localparam int LINE_BYTES = 32;

    localparam logic [2:0] LOAD_NONE  = 3'd0;
    localparam logic [2:0] LOAD_BYTE  = 3'd1;
    localparam logic [2:0] LOAD_HALF  = 3'd2;
    localparam logic [2:0] LOAD_WORD  = 3'd3;
    localparam logic [2:0] LOAD_DWORD = 3'd4;

    localparam logic [2:0] NO_STORE    = 3'd0;
    localparam logic [2:0] STORE_BYTE  = 3'd1;
    localparam logic [2:0] STORE_HALF  = 3'd2;
    localparam logic [2:0] STORE_WORD  = 3'd3;
    localparam logic [2:0] STORE_DWORD = 3'd4;

    localparam logic [2:0] CACHE_IDX_INV    = 3'd0;
    localparam logic [2:0] CACHE_HIT_INV    = 3'd4;
    localparam logic [2:0] CACHE_HIT_WB_INV = 3'd5;
    localparam logic [2:0] CACHE_HIT_WB     = 3'd6;

    typedef enum logic [1:0] {
        ICACHE = 2'd0,
        DCACHE = 2'd1
    } cache_target_t;

    typedef struct packed {
        cache_target_t t;
        logic [2:0]    op;
    } cache_action_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } mem_bus_req_t;

    typedef struct packed {
        logic         mem_ready;
        logic [255:0] rdata;
    } mem_bus_resp_t;

    // Byte lane inside a doubleword, with bits below the access size dropped.
    function automatic logic [2:0] lane_of(logic [2:0] size, logic [2:0] off);
        case (size)
            LOAD_HALF:  return {off[2:1], 1'b0};
            LOAD_WORD:  return {off[2], 2'b00};
            LOAD_DWORD: return 3'd0;
            default:    return off;
        endcase
    endfunction

    function automatic logic [7:0] size_strb(logic [2:0] size);
        case (size)
            STORE_BYTE:  return 8'h01;
            STORE_HALF:  return 8'h03;
            STORE_WORD:  return 8'h0F;
            STORE_DWORD: return 8'hFF;
            default:     return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/cache_l1_extract.sv
// cache_l1_extract: picks the addressed bytes out of a 32-byte line and
// sign/zero extends them to 64 bits.
module cache_l1_extract
    import cache_l1_pkg::*;
(
    input  logic [255:0] line,
    input  logic [4:0]   offset,
    input  logic [2:0]   load_type,
    input  logic         signed_type,
    output logic [63:0]  value
);

    logic [63:0] dw;
    logic [63:0] sh;

    always_comb begin
        dw = line[{offset[4:3], 6'b0} +: 64];
        sh = dw >> {lane_of(load_type, offset[2:0]), 3'b0};
        unique case (load_type)
            LOAD_BYTE: value = {{56{signed_type & sh[7]}}, sh[7:0]};
            LOAD_HALF: value = {{48{signed_type & sh[15]}}, sh[15:0]};
            LOAD_WORD: value = {{32{signed_type & sh[31]}}, sh[31:0]};
            default:   value = sh;
        endcase
    end

endmodule

// File: rtl/cache_l1.sv
// cache_l1: direct-mapped write-through, no-write-allocate L1 data cache
// with a one-cycle registered load result and CACHE invalidate support.
module cache_l1
    import cache_l1_pkg::*;
#(
    parameter int SETS = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic          signed_type,
    input  logic [63:0]   addr,
    input  logic [63:0]   wdata,
    input  logic [2:0]    mem_load_type,
    input  logic [2:0]    mem_store_type,
    output logic [63:0]   rdata,
    output logic          miss,
    input  logic          cache_inst,
    input  logic [2:0]    cache_op,
    output mem_bus_req_t  req,
    input  mem_bus_resp_t resp
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 64 - 5 - IW;

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [255:0]    data_q [SETS];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit;
    logic          op_cache;
    logic          op_load;
    logic          op_store;
    logic          refill;
    logic          ld_done;
    logic          st_done;
    logic          inv;
    logic [2:0]    st_lane;
    logic [7:0]    st_size;
    logic [7:0]    st_strb;
    logic [63:0]   st_mask;
    logic [63:0]   st_data;
    logic [255:0]  st_line;
    logic [255:0]  ld_line;
    logic [63:0]   ld_value;

    assign idx = addr[5 +: IW];
    assign tag = addr[63 -: TW];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        op_cache = enable && cache_inst;
        op_load  = enable && !cache_inst && (mem_load_type != LOAD_NONE);
        op_store = enable && !cache_inst && (mem_load_type == LOAD_NONE)
                   && (mem_store_type != NO_STORE);
    end

    // Loads are a miss only without a hit; every store goes to the bus.
    assign miss    = !reset && ((op_load && !hit) || op_store);
    assign refill  = op_load && !hit && resp.mem_ready;
    assign ld_done = op_load && (hit || resp.mem_ready);
    assign st_done = op_store && hit && resp.mem_ready;

    always_comb begin
        inv = 1'b0;
        unique case (1'b1)
            op_cache && (cache_op == CACHE_IDX_INV): inv = 1'b1;
            op_cache && (cache_op inside {CACHE_HIT_INV, CACHE_HIT_WB_INV,
                                         CACHE_HIT_WB}): inv = hit;
            default: inv = 1'b0;
        endcase
    end

    always_comb begin
        st_lane = lane_of(mem_store_type, addr[2:0]);
        st_size = size_strb(mem_store_type);
        st_strb = st_size << st_lane;
        for (int b = 0; b < 8; b++) begin
            st_mask[b*8 +: 8] = {8{st_size[b]}};
        end
        st_data = (wdata & st_mask) << {st_lane, 3'b0};
    end

    always_comb begin
        st_line = data_q[idx];
        for (int b = 0; b < 8; b++) begin
            if (st_strb[b]) begin
                st_line[{addr[4:3], 3'(b), 3'b0} +: 8] = st_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        req = '0;
        req.valid = miss;
        if (miss && op_load) begin
            req.addr = {addr[63:5], 5'b0};
        end else if (miss) begin
            req.we    = 1'b1;
            req.addr  = {addr[63:3], 3'b0};
            req.wdata = st_data;
            req.wstrb = st_strb;
        end
    end

    assign ld_line = hit ? data_q[idx] : resp.rdata;

    cache_l1_extract u_extract (
        .line        (ld_line),
        .offset      (addr[4:0]),
        .load_type   (mem_load_type),
        .signed_type (signed_type),
        .value       (ld_value)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rdata   <= '0;
        end else begin
            if (ld_done) begin
                rdata <= ld_value;
            end
            if (clear) begin
                valid_q <= '0;
            end else if (refill) begin
                valid_q[idx] <= 1'b1;
            end else if (inv) begin
                valid_q[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (refill) begin
            data_q[idx] <= resp.rdata;
            tag_q[idx]  <= tag;
        end else if (st_done) begin
            data_q[idx] <= st_line;
        end
    end

endmodule

// File: tb/tb_cache_l1.sv
// tb_cache_l1: random and directed traffic against a flat memory model;
// load results are queued at issue and checked when the cache delivers.
module tb_cache_l1;
    import cache_l1_pkg::*;

    localparam int SETS = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          clear;
    logic          signed_type;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [2:0]    mem_load_type;
    logic [2:0]    mem_store_type;
    logic [63:0]   rdata;
    logic          miss;
    logic          cache_inst;
    logic [2:0]    cache_op;
    mem_bus_req_t  req;
    mem_bus_resp_t resp;

    always #5 clock = ~clock;

    cache_l1 #(.SETS(SETS)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .clear          (clear),
        .signed_type    (signed_type),
        .addr           (addr),
        .wdata          (wdata),
        .mem_load_type  (mem_load_type),
        .mem_store_type (mem_store_type),
        .rdata          (rdata),
        .miss           (miss),
        .cache_inst     (cache_inst),
        .cache_op       (cache_op),
        .req            (req),
        .resp           (resp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mem [logic [63:0]];
    bit          vld [SETS];
    logic [63:0] line_of [SETS];
    logic [63:0] exp_q [$];
    logic [63:0] last_rd = '0;
    logic [63:0] mon_exp;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rd_dw(logic [63:0] k);
        if (!mem.exists(k)) mem[k] = {$urandom, $urandom};
        return mem[k];
    endfunction

    function automatic logic [255:0] line_data(logic [63:0] la);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = rd_dw(la * 4 + 64'(k));
        return l;
    endfunction

    function automatic logic [63:0] ref_load(logic [63:0] a, logic [2:0] t, logic s);
        int nb = 1 << (int'(t) - 1);
        int off = int'(a[2:0]) & ~(nb - 1);
        logic [63:0] v = rd_dw(a >> 3) >> (off * 8);
        logic [63:0] m;
        if (nb == 8) return v;
        m = (64'd1 << (nb * 8)) - 64'd1;
        v = v & m;
        if (s && v[nb*8-1]) v = v | ~m;
        return v;
    endfunction

    function automatic int set_of(logic [63:0] a);
        return int'((a >> 5) % SETS);
    endfunction

    function automatic bit model_hit(logic [63:0] a);
        return vld[set_of(a)] && line_of[set_of(a)] == (a >> 5);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        mem_load_type  = LOAD_NONE;
        mem_store_type = NO_STORE;
        cache_inst     = 1'b0;
        clear          = 1'b0;
        resp.mem_ready = 1'b0;
    endtask

    task automatic do_load(logic [63:0] a, logic [2:0] t, logic s, int lat, logic clr);
        bit h = model_hit(a);
        int set = set_of(a);
        enable = 1'b1; addr = a; mem_load_type = t; signed_type = s;
        exp_q.push_back(ref_load(a, t, s));
        @(negedge clock);
        chk("load_miss", 64'(miss), 64'(!h));
        if (!h) begin
            chk("ld_req_valid", 64'(req.valid), 64'd1);
            chk("ld_req_we", 64'(req.we), 64'd0);
            chk("ld_req_addr", req.addr, a & ~64'd31);
            chk("ld_req_wstrb", 64'(req.wstrb), 64'd0);
            repeat (lat) begin
                step();
                @(negedge clock);
                chk("ld_miss_hold", 64'(miss), 64'd1);
            end
            step();
            resp.mem_ready = 1'b1;
            resp.rdata = line_data(a >> 5);
            clear = clr;
        end
        step();
        if (!h) begin
            line_of[set] = a >> 5;
            vld[set] = 1'b1;
            if (clr) for (int i = 0; i < SETS; i++) vld[i] = 1'b0;
        end
        idle();
    endtask

    task automatic do_store(logic [63:0] a, logic [2:0] t, logic [63:0] d, int lat);
        int nb = 1 << (int'(t) - 1);
        int off = int'(a[2:0]) & ~(nb - 1);
        logic [7:0] strb = 8'(((1 << nb) - 1) << off);
        logic [63:0] msk = (nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
        logic [63:0] wd = (d & msk) << (off * 8);
        logic [63:0] dw;
        enable = 1'b1; addr = a; mem_store_type = t; wdata = d;
        @(negedge clock);
        chk("st_miss", 64'(miss), 64'd1);
        chk("st_req_we", {62'd0, req.valid, req.we}, 64'd3);
        chk("st_req_addr", req.addr, a & ~64'd7);
        chk("st_req_wstrb", 64'(req.wstrb), 64'(strb));
        chk("st_req_wdata", req.wdata, wd);
        repeat (lat) begin
            step();
            @(negedge clock);
            chk("st_miss_hold", 64'(miss), 64'd1);
        end
        step();
        resp.mem_ready = 1'b1;
        step();
        dw = rd_dw(a >> 3);
        for (int b = 0; b < 8; b++) if (strb[b]) dw[b*8 +: 8] = wd[b*8 +: 8];
        mem[a >> 3] = dw;
        idle();
    endtask

    task automatic do_cache(logic [63:0] a, logic [2:0] op, logic with_load);
        bit h = model_hit(a);
        enable = 1'b1; addr = a; cache_inst = 1'b1; cache_op = op;
        mem_load_type = with_load ? LOAD_WORD : LOAD_NONE;
        @(negedge clock);
        chk("cache_miss", 64'(miss), 64'd0);
        chk("cache_req_valid", 64'(req.valid), 64'd0);
        step();
        if (op == 3'd0 || ((op == 3'd4 || op == 3'd5 || op == 3'd6) && h)) vld[set_of(a)] = 1'b0;
        idle();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < SETS; i++) vld[i] = 1'b0;
    endtask

    // Scoreboard side: a load completes on the edge after a hit or mem_ready.
    always @(negedge clock) begin
        if (!reset && enable && !cache_inst && mem_load_type != LOAD_NONE
            && (!miss || resp.mem_ready)) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdata_unexpected: got %h want none", rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rdata", rdata, mon_exp);
                last_rd = mon_exp;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    logic [63:0] tags [4] = '{64'h0, 64'h0000_0100_0000_0000,
                              64'h8000_0000_0000_0000, 64'hC000_0000_0000_0800};
    logic [2:0]  ops [6] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0; signed_type = 1'b0;
        addr = 64'h1000; wdata = '0; mem_load_type = LOAD_NONE;
        mem_store_type = NO_STORE; cache_inst = 1'b0; cache_op = '0; resp = '0;
        for (int i = 0; i < SETS; i++) begin
            vld[i] = 1'b0;
            line_of[i] = '0;
        end
        repeat (2) step();
        @(negedge clock);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_miss", 64'(miss), 64'd0);
        chk("rst_req_valid", 64'(req.valid), 64'd0);
        step();
        reset = 1'b0;

        mem[64'h1000 >> 3] = 64'h0000_0000_8000_0001;
        do_load(64'h1000, LOAD_WORD, 1'b1, 2, 1'b0);
        chk("plan_word_signed", rdata, 64'hFFFF_FFFF_8000_0001);
        do_load(64'h1000, LOAD_WORD, 1'b1, 0, 1'b0);
        do_store(64'h1003, STORE_BYTE, 64'hAB, 1);
        do_load(64'h1003, LOAD_BYTE, 1'b0, 0, 1'b0);
        chk("plan_byte_u", rdata, 64'hAB);
        do_load(64'h1003, LOAD_BYTE, 1'b1, 0, 1'b0);
        chk("plan_byte_s", rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        do_store(64'h1006, STORE_HALF, 64'h1234, 0);
        do_load(64'h1006, LOAD_HALF, 1'b0, 0, 1'b0);
        chk("plan_half", rdata, 64'h1234);
        do_store(64'h2000, STORE_WORD, 64'hDEAD_BEEF, 1);
        do_load(64'h2000, LOAD_WORD, 1'b0, 1, 1'b0);
        do_load(64'h1000, LOAD_DWORD, 1'b1, 0, 1'b0);

        // Disabled cache: no bus traffic, no state change, rdata holds.
        enable = 1'b0; addr = 64'h1000; mem_store_type = STORE_WORD;
        wdata = '1; resp.mem_ready = 1'b1;
        @(negedge clock);
        chk("dis_miss", 64'(miss), 64'd0);
        chk("dis_req_valid", 64'(req.valid), 64'd0);
        step();
        idle();
        mem_load_type = LOAD_WORD;
        @(negedge clock);
        chk("dis_load_miss", 64'(miss), 64'd0);
        step();
        chk("dis_rdata_hold", rdata, last_rd);
        idle();
        enable = 1'b1;
        do_load(64'h1000, LOAD_WORD, 1'b0, 0, 1'b0);

        do_cache(64'h1000, 3'd4, 1'b1);
        do_load(64'h1000, LOAD_WORD, 1'b0, 0, 1'b0);
        do_cache(64'h9000, 3'd4, 1'b0);
        do_cache(64'h1000, 3'd7, 1'b0);
        do_load(64'h1004, LOAD_WORD, 1'b1, 0, 1'b0);
        do_cache(64'h9000, 3'd0, 1'b0);
        do_load(64'h1000, LOAD_HALF, 1'b1, 1, 1'b0);
        do_clear();
        do_load(64'h1000, LOAD_WORD, 1'b0, 0, 1'b0);
        do_load(64'h2000, LOAD_WORD, 1'b0, 0, 1'b0);
        do_load(64'h3000, LOAD_WORD, 1'b0, 0, 1'b1);
        do_load(64'h3000, LOAD_WORD, 1'b0, 0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            int kind = $urandom_range(0, 9);
            logic [2:0] t = 3'($urandom_range(1, 4));
            int off = $urandom_range(0, 31) & ~((1 << (int'(t) - 1)) - 1);
            logic [63:0] a = tags[$urandom_range(0, 3)]
                             | (64'($urandom_range(0, 3)) << 5) | 64'(off);
            if (kind <= 5) begin
                do_load(a, t, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                        $urandom_range(0, 15) == 0);
            end else if (kind <= 7) begin
                do_store(a, t, {$urandom, $urandom}, $urandom_range(0, 2));
            end else if (kind == 8) begin
                do_cache(a, ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 3) == 0) begin
                do_clear();
            end else begin
                do_load(a, t, 1'b1, 0, 1'b0);
            end
        end

        // Reset while a refill is outstanding.
        do_load(64'h1000, LOAD_WORD, 1'b0, 0, 1'b0);
        enable = 1'b1; addr = 64'h5000; mem_load_type = LOAD_WORD;
        step();
        @(negedge clock);
        chk("pre_rst_miss", 64'(miss), 64'(!model_hit(64'h5000)));
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_req_valid", 64'(req.valid), 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        step();
        idle();
        reset = 1'b0;
        for (int i = 0; i < SETS; i++) vld[i] = 1'b0;
        do_load(64'h1000, LOAD_WORD, 1'b0, 0, 1'b0);

        step();
        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_l1.md
Name: cache_l1

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits in the MEM stage between the core load/store unit and the shared memory bus.
- Serves byte/half/word/doubleword loads with a one-cycle registered read; forwards every store to memory.
- Supports MIPS CACHE invalidate operations.

Parameters:
SETS, 64, number of lines (power of 2); each line is 32 bytes, so offset = addr[4:0], index = addr[5 +: log2(SETS)], tag = remaining upper bits.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  0 = cache ignores all requests; miss=0, req.valid=0
clear  input  1  synchronous invalidate of all lines
signed_type  input  1  1 = sign-extend load result, 0 = zero-extend
addr  input  64  byte address of the access (low bits below the access size are ignored)
wdata  input  64  store data, right-aligned
mem_load_type  input  3  0 NONE, 1 BYTE, 2 HALF, 3 WORD (LOAD_WORD), 4 DWORD
mem_store_type  input  3  0 NO_STORE, 1 BYTE, 2 HALF, 3 WORD, 4 DWORD
rdata  output  64  registered, extended load result
miss  output  1  combinational: access pending, core must stall while miss && !resp.mem_ready
cache_inst  input  1  execute CACHE operation this cycle
cache_op  input  3  CACHE operation code
req  output  mem_bus_req_t  {valid, we, addr[63:0], wdata[63:0], wstrb[7:0]}
resp  input  mem_bus_resp_t  {mem_ready, rdata[255:0] line}

Behaviour:
- Reset (async): all valid bits cleared; rdata=0. req.valid is combinational and is 0 while no miss.
- Hit: line valid and tag equal at index.
- Load hit:
  - miss=0.
  - At the next edge, rdata <= selected bytes (little-endian lane from addr[4:0]), extended per signed_type.
  - DWORD is never extended.
- Load miss:
  - miss=1; req = {valid=1, we=0, addr line-aligned (addr & ~31), wdata=0, wstrb=0}.
  - Hold until resp.mem_ready=1.
  - On that edge: line data <= resp.rdata, tag written, valid set; rdata <= bytes extracted from resp.rdata.
- Store (any size):
  - miss=1 until mem_ready; req = {valid=1, we=1, addr & ~7, wdata shifted into lane addr[2:0], wstrb = size mask << addr[2:0]}.
  - On the mem_ready edge, if the store hits, the cached bytes are updated. No allocation on a store miss.
- mem_load_type and mem_store_type both nonzero does not occur; load takes priority.
- cache_inst (no bus traffic, miss=0, completes on the edge):
  - op 0: index invalidate at addr index.
  - op 4: hit invalidate.
  - op 5 and 6: treated as hit invalidate (no dirty data exists).
  - Other ops: no-op.
- cache_inst takes priority over load/store in the same cycle.
- clear: all valid bits cleared on the edge; an access completing the same edge does not set its valid bit.
- rdata holds its value on edges where no load completes.
- Reset mid-miss: transaction abandoned, cache empty.
- enable=0: rdata holds, no state change.
- Addresses are naturally aligned; misalignment is not checked.

Decomposition:
- Shared package structures holds:
  - mem_bus_req_t and mem_bus_resp_t
  - load/store type constants (LOAD_WORD, NO_STORE, ...)
  - cache_action_t {t[1:0], op[2:0]} with DCACHE/ICACHE target enums
- Natural sub-module: cache_l1_extract, which does byte-lane selection plus sign/zero extension (used for both hit and refill paths).
- Tag/data/valid arrays stay inline.

Test Plan:
- Load WORD 0x1000 on a cold cache → miss=1, req.addr=0x1000, we=0. Memory returns a line with word 0x80000001 at offset 0 and asserts mem_ready. Edge after → rdata=0xFFFFFFFF80000001 (signed=1); repeat load → miss=0, same rdata next cycle.
- Load BYTE 0x1003, unsigned, line holding 0xAB at byte 3 → hit, rdata=0x00000000000000AB; signed → 0xFFFFFFFFFFFFFFAB.
- Store HALF 0x1006, wdata 0x1234 → req we=1, addr=0x1000, wstrb=0xC0, wdata=0x1234000000000000; after mem_ready, load HALF 0x1006 hits with rdata=0x1234.
- Store WORD to uncached 0x2000 → memory write issued; subsequent load 0x2000 misses (no allocate).
- cache_inst op 4 at 0x1000, then load 0x1000 → miss=1. Separately, clear=1 → all previously hit addresses miss.
- Assert reset during an outstanding miss → req.valid drops to 0, rdata=0, previously cached lines miss.
